// File: rtl/cnn_frame_arbiter.sv
// Two-requester frame arbiter in front of a CNN core: whole input frames are granted
// round-robin, and each frame's result words are routed back to its owner via a tag FIFO.
//
// state  | meaning
// IDLE   | no frame granted; arbitrating, both sources stalled
// STREAM | forwarding grant_id's words to the CNN until FRAME_WORDS have transferred
module cnn_frame_arbiter #(
  parameter int WIDTH        = 32,
  parameter int FRAME_WORDS  = 784,
  parameter int RESULT_WORDS = 10,
  parameter int TAG_DEPTH    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] src_data,
  input  logic [1:0]         src_valid,
  output logic [1:0]         src_stall,
  output logic [WIDTH-1:0]   cnn_in_data,
  output logic               cnn_in_valid,
  input  logic               cnn_upstream_stall,
  input  logic [WIDTH-1:0]   cnn_out_data,
  input  logic               cnn_out_valid,
  output logic               cnn_downstream_stall,
  output logic [WIDTH-1:0]   res_data,
  output logic [1:0]         res_valid,
  input  logic [1:0]         res_stall,
  output logic               busy,
  output logic               grant_id
);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam int WC_W  = $clog2(FRAME_WORDS + 1);
  localparam int RC_W  = $clog2(RESULT_WORDS + 1);
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TC_W  = $clog2(TAG_DEPTH + 1);

  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(FRAME_WORDS - 1);
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RESULT_WORDS - 1);
  localparam logic [TC_W-1:0] TAG_FULL = TC_W'(TAG_DEPTH);

  logic [0:0]           state;
  logic                 last_grant;
  logic [WC_W-1:0]      word_cnt;
  logic [RC_W-1:0]      res_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [TC_W-1:0]      tag_cnt;

  logic tag_empty, tag_full, tag_head;
  logic arb_pick, grant_fire, in_fire, res_fire, tag_pop;

  assign busy      = (state == ST_STREAM);
  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == TAG_FULL);
  assign tag_head  = tag_mem[rd_ptr];

  // Round-robin only matters when both want the link; a lone requester always wins.
  assign arb_pick   = (&src_valid) ? ~last_grant : src_valid[1];
  assign grant_fire = !busy && (|src_valid) && !tag_full;
  assign in_fire    = busy && src_valid[grant_id] && !cnn_upstream_stall;
  assign res_fire   = !tag_empty && cnn_out_valid && !res_stall[tag_head];
  assign tag_pop    = res_fire && (res_cnt == RC_LAST);

  always_comb begin
    cnn_in_data  = grant_id ? src_data[2*WIDTH-1:WIDTH] : src_data[WIDTH-1:0];
    cnn_in_valid = busy && src_valid[grant_id];
    src_stall    = 2'b11;
    if (busy) src_stall[grant_id] = cnn_upstream_stall;

    res_data             = cnn_out_data;
    res_valid            = 2'b00;
    cnn_downstream_stall = 1'b1;
    if (!tag_empty) begin
      res_valid[tag_head]  = cnn_out_valid;
      cnn_downstream_stall = res_stall[tag_head];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      word_cnt   <= '0;
    end else if (grant_fire) begin
      state    <= ST_STREAM;
      grant_id <= arb_pick;
      word_cnt <= '0;
    end else if (in_fire) begin
      word_cnt <= word_cnt + 1'b1;
      if (word_cnt == WC_LAST) begin
        state      <= ST_IDLE;
        last_grant <= grant_id;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      res_cnt <= '0;
    end else begin
      if (grant_fire) begin
        tag_mem[wr_ptr] <= arb_pick;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (res_fire) res_cnt <= tag_pop ? '0 : res_cnt + 1'b1;
      if (tag_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant_fire, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_arbiter.sv
// Randomized bench for cnn_frame_arbiter; a queue-based frame/tag model predicts
// every output each cycle, plus scenario-specific counts and sequences.
module tb_cnn_frame_arbiter;
  localparam int W  = 16;
  localparam int FW = 4;
  localparam int RW = 2;
  localparam int TD = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [2*W-1:0] src_data = '0;
  logic [1:0]     src_valid = 2'b00;
  logic [1:0]     src_stall;
  logic [W-1:0]   cnn_in_data;
  logic           cnn_in_valid;
  logic           cnn_upstream_stall = 1'b0;
  logic [W-1:0]   cnn_out_data = '0;
  logic           cnn_out_valid = 1'b0;
  logic           cnn_downstream_stall;
  logic [W-1:0]   res_data;
  logic [1:0]     res_valid;
  logic [1:0]     res_stall = 2'b00;
  logic           busy;
  logic           grant_id;

  cnn_frame_arbiter #(.WIDTH(W), .FRAME_WORDS(FW), .RESULT_WORDS(RW), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_stall(src_stall),
    .cnn_in_data(cnn_in_data), .cnn_in_valid(cnn_in_valid),
    .cnn_upstream_stall(cnn_upstream_stall),
    .cnn_out_data(cnn_out_data), .cnn_out_valid(cnn_out_valid),
    .cnn_downstream_stall(cnn_downstream_stall),
    .res_data(res_data), .res_valid(res_valid), .res_stall(res_stall),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] obs;

  // Reference: a frame is either in flight (owner, words taken) or not; owners of
  // frames awaiting results sit in a queue, oldest first.
  bit m_busy;
  int m_owner, m_last, m_words, m_res;
  int m_seq[2];
  int tagq[$];

  function automatic logic [W-1:0] word_of(int r);
    return W'(r * 32'h8000 + m_seq[r]);
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [1:0] ss, rv;
    logic ds, iv;
    ss = 2'b11;
    iv = 1'b0;
    if (m_busy) begin
      ss[m_owner] = cnn_upstream_stall;
      iv = src_valid[m_owner];
    end
    rv = 2'b00;
    ds = 1'b1;
    if (tagq.size() > 0) begin
      rv[tagq[0]] = cnn_out_valid;
      ds = res_stall[tagq[0]];
    end
    return {m_busy, m_owner[0], ss, iv, ds, rv};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_words = 0; m_res = 0;
    tagq.delete();
  endtask

  task automatic set_data();
    src_data = {word_of(1), word_of(0)};
  endtask

  task automatic sample();
    obs = {busy, grant_id, src_stall, cnn_in_valid, cnn_downstream_stall, res_valid};
  endtask

  task automatic advance();
    bit g, xin, xres;
    int pick;
    g    = !m_busy && (src_valid != 2'b00) && (tagq.size() < TD);
    pick = (src_valid == 2'b11) ? 1 - m_last : (src_valid[1] ? 1 : 0);
    xin  = m_busy && src_valid[m_owner] && !cnn_upstream_stall;
    xres = (tagq.size() > 0) && cnn_out_valid && !res_stall[tagq[0]];
    @(posedge clock);
    #1;
    if (xres) begin
      m_res++;
      if (m_res == RW) begin
        void'(tagq.pop_front());
        m_res = 0;
      end
    end
    if (g) begin
      tagq.push_back(pick);
      m_busy = 1; m_owner = pick; m_words = 0;
    end else if (xin) begin
      m_seq[m_owner]++;
      m_words++;
      if (m_words == FW) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  endtask

  // Lets any open frame finish on its owner's data, then empties the result tags.
  task automatic drain(int n);
    for (int c = 0; c < n; c++) begin
      src_valid = m_busy ? (2'b01 << m_owner) : 2'b00;
      cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      advance();
    end
  endtask

  task automatic test_reset();
    src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
    #3;
    sample();
    checks++;
    if (obs !== 8'b0011_0100) begin
      errors++; $display("FAIL reset_state got %b exp %b", obs, 8'b0011_0100);
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_single_frame();
    int start, n_in, n_res;
    start = m_seq[1]; n_in = 0; n_res = 0;
    for (int c = 0; c < 12; c++) begin
      src_valid = (m_seq[1] - start < FW) ? 2'b10 : 2'b00;
      cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL single_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (m_busy && src_valid[m_owner]) begin checks++; if (cnn_in_data !== word_of(m_owner)) begin errors++; $display("FAIL single_in_data c=%0d got %h exp %h", c, cnn_in_data, word_of(m_owner)); end end
      if (tagq.size() > 0) begin checks++; if (res_data !== cnn_out_data) begin errors++; $display("FAIL single_res_data c=%0d got %h exp %h", c, res_data, cnn_out_data); end end
      if (cnn_in_valid && !cnn_upstream_stall) n_in++;
      if (res_valid == 2'b10) n_res++;
      advance();
    end
    checks++; if (n_in !== FW) begin errors++; $display("FAIL single_words got %0d exp %0d", n_in, FW); end
    checks++; if (n_res !== RW) begin errors++; $display("FAIL single_results got %0d exp %0d", n_res, RW); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    int g[$];
    bit prev_busy;
    prev_busy = 0;
    for (int c = 0; c < 25; c++) begin
      src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rr_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (m_busy && src_valid[m_owner]) begin checks++; if (cnn_in_data !== word_of(m_owner)) begin errors++; $display("FAIL rr_in_data c=%0d got %h exp %h", c, cnn_in_data, word_of(m_owner)); end end
      if (busy && !prev_busy) g.push_back(int'(grant_id));
      prev_busy = busy;
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= g.size() || g[i] !== (i % 2)) begin
        errors++; $display("FAIL rr_grant_seq i=%0d got %0d exp %0d", i, (i < g.size()) ? g[i] : -1, i % 2);
      end
    end
    drain(14);
  endtask

  task automatic test_back_pressure();
    int start, n_in, n_st;
    start = m_seq[0]; n_in = 0; n_st = 0;
    for (int c = 0; c < 12; c++) begin
      src_valid = (m_seq[0] - start < FW) ? 2'b01 : 2'b00;
      cnn_upstream_stall = (c >= 2 && c <= 4); cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL bp_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (m_busy && src_valid[m_owner]) begin checks++; if (cnn_in_data !== word_of(m_owner)) begin errors++; $display("FAIL bp_in_data c=%0d got %h exp %h", c, cnn_in_data, word_of(m_owner)); end end
      if (cnn_in_valid && !cnn_upstream_stall) n_in++;
      if (cnn_upstream_stall && src_stall[0]) n_st++;
      advance();
    end
    checks++; if (n_in !== FW) begin errors++; $display("FAIL bp_words got %0d exp %0d", n_in, FW); end
    checks++; if (n_st !== 3) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 3", n_st); end
    drain(8);
  endtask

  task automatic test_tag_full();
    int first_busy;
    for (int c = 0; c < 18; c++) begin
      src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 0; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL full_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      advance();
    end
    #1;
    checks++; if ({busy, src_stall} !== 3'b011) begin errors++; $display("FAIL full_no_grant got %b exp 011", {busy, src_stall}); end
    first_busy = -1;
    for (int c = 0; c < 6; c++) begin
      src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL full_drain_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (tagq.size() > 0) begin checks++; if (res_data !== cnn_out_data) begin errors++; $display("FAIL full_res_data c=%0d got %h exp %h", c, res_data, cnn_out_data); end end
      if (busy && first_busy < 0) first_busy = c;
      advance();
    end
    checks++; if (first_busy !== 3) begin errors++; $display("FAIL full_regrant_cycle got %0d exp 3", first_busy); end
    drain(14);
  endtask

  task automatic test_result_stall();
    int start, n_early, n_late;
    start = m_seq[0]; n_early = 0; n_late = 0;
    for (int c = 0; c < 12; c++) begin
      src_valid = (m_seq[0] - start < FW) ? 2'b01 : 2'b00;
      cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = (c < 6) ? 2'b01 : 2'b00;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rs_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (tagq.size() > 0) begin checks++; if (res_data !== cnn_out_data) begin errors++; $display("FAIL rs_res_data c=%0d got %h exp %h", c, res_data, cnn_out_data); end end
      if (res_valid[0] && !cnn_downstream_stall) begin
        if (c < 6) n_early++; else n_late++;
      end
      advance();
    end
    checks++; if (n_early !== 0) begin errors++; $display("FAIL rs_held got %0d exp 0", n_early); end
    checks++; if (n_late !== RW) begin errors++; $display("FAIL rs_released got %0d exp %0d", n_late, RW); end
    drain(8);
  endtask

  task automatic test_async_reset();
    int first_grant;
    for (int c = 0; c < 8; c++) begin
      src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 0; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      advance();
    end
    src_valid = 2'b11; cnn_out_valid = 1; set_data();
    #2 reset = 1;
    #1; sample();
    checks++; if (obs !== 8'b0011_0100) begin errors++; $display("FAIL areset_immediate got %b exp %b", obs, 8'b0011_0100); end
    #2 reset = 0;
    model_reset();
    src_valid = 2'b00;
    #1;
    checks++; if ({cnn_downstream_stall, res_valid} !== 3'b100) begin errors++; $display("FAIL areset_tags_empty got %b exp 100", {cnn_downstream_stall, res_valid}); end
    first_grant = -1;
    for (int c = 0; c < 8; c++) begin
      src_valid = 2'b11; cnn_upstream_stall = 0; cnn_out_valid = 1; res_stall = 0;
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL areset_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (busy && first_grant < 0) first_grant = int'(grant_id);
      advance();
    end
    checks++; if (first_grant !== 0) begin errors++; $display("FAIL areset_first_grant got %0d exp 0", first_grant); end
    drain(12);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      src_valid = 2'($urandom);
      cnn_upstream_stall = ($urandom_range(0, 3) == 0);
      cnn_out_valid = ($urandom_range(0, 2) != 0);
      res_stall = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      cnn_out_data = W'($urandom); set_data();
      #1; sample();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rand_ctrl c=%0d got %b exp %b", c, obs, exp_vec()); end
      if (m_busy && src_valid[m_owner]) begin checks++; if (cnn_in_data !== word_of(m_owner)) begin errors++; $display("FAIL rand_in_data c=%0d got %h exp %h", c, cnn_in_data, word_of(m_owner)); end end
      if (tagq.size() > 0) begin checks++; if (res_data !== cnn_out_data) begin errors++; $display("FAIL rand_res_data c=%0d got %h exp %h", c, res_data, cnn_out_data); end end
      advance();
    end
  endtask

  initial begin
    m_seq[0] = 1; m_seq[1] = 1;
    model_reset();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_pressure();
    test_tag_full();
    test_result_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_frame_arbiter.md
CNN_FRAME_ARBITER -- requirements
Module: cnn_frame_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: stream word width.
REQ-002 Parameter FRAME_WORDS, default 784: input words per frame.
REQ-003 Parameter RESULT_WORDS, default 10: result words returned per frame.
REQ-004 Parameter TAG_DEPTH, default 4 (power of 2): max frames in flight.
REQ-005 One clock; reset is asynchronous and active-high. Ports: clock in 1, rising edge; reset in 1, asynchronous active-high.
REQ-006 src_data in 2xWIDTH: frame words from requesters 0 and 1.
REQ-007 src_valid in 2: requester word valid.
REQ-008 src_stall out 2: stall back to each requester.
REQ-009 cnn_in_data out WIDTH: word to the CNN top input.
REQ-010 cnn_in_valid out 1: CNN input valid.
REQ-011 cnn_upstream_stall in 1: CNN cannot accept input.
REQ-012 cnn_out_data in WIDTH: CNN result word.
REQ-013 cnn_out_valid in 1: CNN result valid.
REQ-014 cnn_downstream_stall out 1: stall to the CNN result port.
REQ-015 res_data out WIDTH: result word, shared by both requesters.
REQ-016 res_valid out 2: one-hot result valid per owner.
REQ-017 res_stall in 2: requester result back-pressure.
REQ-018 busy out 1: FSM in STREAM.
REQ-019 grant_id out 1: current or last granted requester.

Function
REQ-020 A transfer occurs on a rising clock edge when valid=1 and stall=0 on that link.
REQ-021 The input FSM SHALL have two states: IDLE and STREAM.
REQ-022 IDLE: if any src_valid=1 and the tag FIFO is not full, go to STREAM next cycle. Latch grant_id. Push grant_id to the tag FIFO. Clear word_cnt.
REQ-023 Arbitration: with a single requester valid, grant that requester. With both valid, grant the requester that is not last_grant (round-robin).
REQ-024 IDLE with the tag FIFO full: stay in IDLE and grant nothing.
REQ-025 In IDLE, src_stall=2'b11 and cnn_in_valid=0.
REQ-026 In STREAM, combinational paths:
- cnn_in_data = src_data[grant_id]
- cnn_in_valid = src_valid[grant_id]
- src_stall[grant_id] = cnn_upstream_stall
- the non-granted src_stall = 1
REQ-027 word_cnt, width $clog2(FRAME_WORDS+1), increments on each input transfer.
REQ-028 On the transfer that makes word_cnt equal FRAME_WORDS: go to IDLE next cycle and set last_grant=grant_id. A frame is never interrupted or pre-empted.
REQ-029 The tag FIFO holds TAG_DEPTH 1-bit owner IDs.
- Push and pop in the same cycle leave the count unchanged.
- A push is never issued when full.
- A pop is never issued when empty.
REQ-030 Tag FIFO empty: cnn_downstream_stall=1, res_valid=0.
REQ-031 Tag FIFO not empty, with head = owner:
- res_data = cnn_out_data
- res_valid[head] = cnn_out_valid
- the other res_valid bit = 0
- cnn_downstream_stall = res_stall[head]
REQ-032 res_cnt counts result transfers. On the RESULT_WORDS-th transfer, pop the tag and clear res_cnt in the same edge.
REQ-033 The input and result paths SHALL operate concurrently. A new frame may stream while earlier results drain.
REQ-034 The only registered state is: FSM, grant_id, last_grant, word_cnt, res_cnt, and tag FIFO pointers/count. The data paths are combinational with zero-cycle latency.

Reset
REQ-035 Reset SHALL asynchronously force the following, taking effect immediately without waiting for a clock edge:
- FSM=IDLE, word_cnt=0, res_cnt=0, tag FIFO empty
- grant_id=0, last_grant=1
- outputs: busy=0, src_stall=2'b11, cnn_in_valid=0, cnn_downstream_stall=1, res_valid=0
REQ-036 Reset asserted mid-frame SHALL discard the partial frame and all in-flight tags. After deassertion, the first grant goes to requester 0 if both requesters are valid.

Verification (FRAME_WORDS=4, RESULT_WORDS=2, TAG_DEPTH=2)
REQ-037 Single frame:
- Stimulus: requester 1 valid with words A1..A4, no stalls, CNN returns R1,R2.
- Response: cnn_in sees A1..A4 on 4 consecutive cycles after the grant cycle; res_valid=2'b10 for R1,R2; busy falls after A4.
REQ-038 Round-robin:
- Stimulus: both requesters continuously valid.
- Response: grants alternate 0,1,0,1; each frame is exactly 4 words; there is one IDLE cycle between frames.
REQ-039 Back-pressure:
- Stimulus: cnn_upstream_stall=1 for 3 cycles mid-frame.
- Response: src_stall[grant]=1 for those cycles, word_cnt holds, and no word is lost or duplicated.
REQ-040 Tag full:
- Stimulus: cnn_out_valid=0 while 2 frames complete.
- Response: the third request is not granted.
- Then the first 2 results drain, the tag pops, and the third frame is granted on the following cycle.
REQ-041 Result stall:
- Stimulus: head=0 with res_stall[0]=1.
- Response: cnn_downstream_stall=1, the result is held, and res_cnt does not advance.
REQ-042 Async reset:
- Stimulus: reset pulses mid-frame between clock edges.
- Response: outputs take their reset values before the next edge, and the tag FIFO is empty afterwards.
